// File: rtl/pipe_read_mux.sv
// pipe_read_mux: two-stage pipelined N:1 register-file read select.
// Stage 1 snapshots one word per GROUP-entry group, the upper select bits and
// any same-cycle write bypass. Stage 2 picks the final word. A valid/ready
// handshake gives full backpressure at one result per cycle.
module pipe_read_mux #(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int GROUP    = 8,
    parameter  int ZERO_REG = 1,
    localparam int SW       = $clog2(DEPTH),
    localparam int GW       = $clog2(GROUP)
) (
    input  logic                   clock,
    input  logic                   ctrl_reset,
    input  logic [DEPTH*WIDTH-1:0] in_flat,
    input  logic [SW-1:0]          select,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   wr_en,
    input  logic [SW-1:0]          wr_sel,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    // Number of first-level groups and width of the group index.
    localparam int NG = DEPTH / GROUP;
    localparam int UW = SW - GW;
    localparam bit ZERO_EN = 1'(ZERO_REG);

    // Register array viewed as indexable entries.
    logic [DEPTH-1:0][WIDTH-1:0] entries_s;

    // First-level group words for the current select.
    logic [NG-1:0][WIDTH-1:0]    grp_s;

    logic                        zero_sel_s;
    logic                        byp_hit_s;
    logic                        accept_s;
    logic                        s2_load_s;
    logic                        in_ready_s;
    logic [WIDTH-1:0]            s2_next_s;

    // Stage 1 state: snapshot of the group words and steering information.
    logic                        s1_v_r;
    logic [NG-1:0][WIDTH-1:0]    s1_grp_r;
    logic [UW-1:0]               s1_upper_r;
    logic                        s1_byp_r;
    logic [WIDTH-1:0]            s1_byp_data_r;
    logic                        s1_zero_r;

    // Stage 2 state: the delivered result.
    logic                        s2_v_r;
    logic [WIDTH-1:0]            s2_data_r;

    assign entries_s = in_flat;

    // First-level selection: within each group, pick the entry named by the low select bits.
    always_comb begin
        for (int g = 0; g < NG; g++) begin
            grp_s[g] = entries_s[{g[UW-1:0], select[GW-1:0]}];
        end
    end

    // Request classification: hard-wired zero entry and same-cycle write bypass.
    always_comb begin
        if (ZERO_EN && (select == {SW{1'b0}})) begin
            zero_sel_s = 1'b1;
        end else begin
            zero_sel_s = 1'b0;
        end
        if (wr_en && (wr_sel == select) && !zero_sel_s) begin
            byp_hit_s = 1'b1;
        end else begin
            byp_hit_s = 1'b0;
        end
    end

    // Handshake: stage 2 loads when it is empty or being drained; stage 1 accepts when it can hand off.
    always_comb begin
        if (!s1_v_r || !s2_v_r || out_ready) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        if (s1_v_r && (!s2_v_r || out_ready)) begin
            s2_load_s = 1'b1;
        end else begin
            s2_load_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Second-level selection: zero entry wins, then bypass data, then the captured group word.
    always_comb begin
        if (s1_zero_r) begin
            s2_next_s = {WIDTH{1'b0}};
        end else if (s1_byp_r) begin
            s2_next_s = s1_byp_data_r;
        end else begin
            s2_next_s = s1_grp_r[s1_upper_r];
        end
    end

    // Stage 1 registers: capture the snapshot on accept, drop valid once handed to stage 2.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            s1_v_r        <= 1'b0;
            s1_grp_r      <= {(NG*WIDTH){1'b0}};
            s1_upper_r    <= {UW{1'b0}};
            s1_byp_r      <= 1'b0;
            s1_byp_data_r <= {WIDTH{1'b0}};
            s1_zero_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                s1_v_r        <= 1'b1;
                s1_grp_r      <= grp_s;
                s1_upper_r    <= select[SW-1:GW];
                s1_byp_r      <= byp_hit_s;
                s1_byp_data_r <= wr_data;
                s1_zero_r     <= zero_sel_s;
            end else if (s2_load_s) begin
                s1_v_r        <= 1'b0;
            end
        end
    end

    // Stage 2 registers: load on advance, clear valid when consumed with nothing behind it.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            s2_v_r    <= 1'b0;
            s2_data_r <= {WIDTH{1'b0}};
        end else begin
            if (s2_load_s) begin
                s2_v_r    <= 1'b1;
                s2_data_r <= s2_next_s;
            end else if (out_ready) begin
                s2_v_r    <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_v_r;
    assign out_data  = s2_data_r;

endmodule

// File: doc/pipe_read_mux.md
# pipe_read_mux

Parametrised, two-stage pipelined N:1 read-select block: the successor to the combinational 32-way word mux on the register-file read ports. It selects one WIDTH-bit word from a flattened DEPTH-entry register array, applies same-cycle write bypass and an optional hard-wired zero entry, and delivers the result through a valid/ready handshake with full backpressure. One instance sits on each register-file read port, between the flop array and the operand-fetch stage.

## Interface
- WIDTH, 32: word width in bits.
- DEPTH, 32: number of entries; power of 2, at least 4.
- GROUP, 8: first-level fan-in; power of 2, at least 2, divides DEPTH, less than DEPTH.
- ZERO_REG, 1: 1 makes entry 0 always read as 0, with no bypass.
- SW = log2(DEPTH), GW = log2(GROUP) (derived localparams).

- clock  in  1  single clock, rising edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- in_flat  in  DEPTH*WIDTH  register array; entry k = in_flat[k*WIDTH +: WIDTH].
- select  in  SW  entry index to read.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle when in_valid && in_ready.
- wr_en  in  1  register-file write this cycle.
- wr_sel  in  SW  write index.
- wr_data  in  WIDTH  write data.
- out_data  out  WIDTH  selected word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.

## Operation
- Clock is `clock`. Reset is `ctrl_reset`: one clock domain, synchronous, active-high.
- Stage 1 (S1) captures on accept: DEPTH/GROUP group words, each chosen by select[GW-1:0] from its GROUP entries. It also captures select[SW-1:GW], a bypass flag and the bypass data.
- Bypass condition at accept: wr_en && wr_sel == select && !(ZERO_REG && select == 0). When it holds, the captured bypass data is wr_data and it overrides the group result.
- Stage 2 (S2) captures on advance. It takes the group word indexed by the S1 upper select bits, or the bypass data when the flag is set. With ZERO_REG=1 and a full select of 0, it loads 0.
- Snapshot semantics: the value is fixed at the accept cycle. Later writes or in_flat changes do not alter an entry already in S1 or S2.
- Valid bits s1_v and s2_v (s2_v drives out_valid).
  - s2 advances (load) when s1_v && (!s2_v || out_ready).
  - s2_v clears when it is consumed and nothing loads.
  - in_ready = !s1_v || !s2_v || out_ready, which is combinational from out_ready.
  - s1 loads on accept. s1_v clears when s1 advances and there is no accept in the same cycle.
- No bubbles: a 2-entry pipeline sustains one result per cycle while out_ready stays high.
- Requests leave in order. Results are not dropped or duplicated.
- out_data holds stable while out_valid && !out_ready.

## Timing
- Reset: s1_v=0, s2_v=0, out_valid=0, out_data=0, all S1 data registers 0. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards both stages and drops any in-flight results. A request presented during the reset cycle is not accepted.
- Latency: a request accepted at edge N produces out_valid=1 after edge N+1, when S2 is free.
- Throughput: 1 per cycle. Under full stall (out_ready=0, both stages valid), in_ready=0.
- Simultaneous events:
  - Consume and load in the same cycle: s2 is replaced, out_valid stays 1.
  - Accept and s1 advance in the same cycle: s1 holds the new request, s1_v stays 1.
- wr_en with wr_sel matching a request that is not accepted (in_ready=0) has no effect on that request. Bypass is evaluated again on the cycle it is accepted.
- in_flat, select, wr_* are sampled only at edges. There is no combinational path from them to outputs.

## Test plan
- Sweep, WIDTH=32, DEPTH=32, GROUP=8, entry k = 0x1000_0000 + k: select 0..31 back-to-back with out_ready=1. Expected: out_data 0x1000_0001..0x1000_001F for 1..31, 0 for select 0 (ZERO_REG=1), 2-cycle latency, one result per cycle.
- Bypass: select=5 with wr_en=1, wr_sel=5, wr_data=0xDEADBEEF, in_flat[5]=0x11111111 → 0xDEADBEEF. Same with wr_sel=0, select=0 → 0.
- Backpressure: 4 requests (3, 7, 12, 30) with out_ready held 0. Expected: exactly 2 accepted, in_ready=0 afterwards. After releasing out_ready, out_data delivers 3, 7, 12, 30 entries in order with no loss.
- Snapshot: accept select=9, then change in_flat[9] and write to 9 while stalled. Expected: out_data still the original value.
- Reset mid-flight: assert ctrl_reset with both stages valid. Expected: next cycle out_valid=0, out_data=0, in_ready=1, and no stale result appears later.
- Parametrisation: WIDTH=16, DEPTH=64, GROUP=4, ZERO_REG=0. Expected: select 0 returns in_flat[0], and the sweep, bypass and stall checks pass.
